game_clock_bcd: RTL and testbench

//  Elapsed-time display clock for the 2048 game. Consumes the ~1 s period square wave from the
//  500 ms half-period divider (slow_clk). Edge-detects it into a 1 s tick and counts play time
//  as BCD mm:ss. Drives the 7-seg scan driver digits and the blinking colon.

---
 rtl/game_defs_pkg.sv | 14 +
 rtl/bcd_digit_counter.sv | 36 +++
 rtl/game_clock_bcd.sv | 129 ++++++++++++
 tb/tb_game_clock_bcd.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_defs_pkg.sv
// Shared definitions for the game elapsed-time clock: FSM encoding and BCD digit limits.
// Pure declarations; no timing or flow-control behaviour of its own.
package game_defs_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] DEC_MAX      = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } game_state_e;
endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit wrapping at MAX; carry is combinational (en while at MAX) to enable the next digit.
// Updates on the clock after en; clr dominates en; no backpressure.
module bcd_digit_counter
  import game_defs_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);
  logic [DIGIT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = (q_q == MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = en && (q_q == MAX);
endmodule

// File: rtl/game_clock_bcd.sv
// BCD mm:ss play-time clock counting rising edges of slow_clk; all outputs registered, 1 clk latency.
// Optional GAME_TIMEOUT_EN adds a seconds total that raises a sticky time_up and halts at TIME_LIMIT_S.
module game_clock_bcd
  import game_defs_pkg::*;
#(
  parameter int MAX_MIN      = 99,
  parameter int TIME_LIMIT_S = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       game_over_in,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       colon_on,
  output logic       running,
  output logic       tick_1s,
  output logic       time_up
);
  localparam logic [DIGIT_W-1:0] MAX_MT = DIGIT_W'(MAX_MIN / 10);
  localparam logic [DIGIT_W-1:0] MAX_MO = DIGIT_W'(MAX_MIN % 10);

  game_state_e state_q, state_d;
  logic slow_prev_q, tick_q, colon_q, running_q;
  logic slow_rise, at_max, count_en, sat_hit, limit_hit;
  logic c_so, c_st, c_mo, mt_carry_unused;

  assign slow_rise = slow_clk & ~slow_prev_q;
  assign at_max    = (min_tens == MAX_MT) && (min_ones == MAX_MO) &&
                     (sec_tens == SEC_TENS_MAX) && (sec_ones == DEC_MAX);
  // Counting decision uses the current state, so a tick coinciding with pause/game_over still lands.
  assign count_en  = (state_q == ST_RUN) && slow_rise && !clear && !at_max;
  assign sat_hit   = (state_q == ST_RUN) && slow_rise && !clear && at_max;

`ifdef GAME_TIMEOUT_EN
  localparam logic [6:0] LIMIT = 7'(TIME_LIMIT_S);
  logic [6:0] total_q, total_d;
  logic       time_up_q, time_up_d;

  assign limit_hit = count_en && (total_q + 7'd1 == LIMIT);

  always_comb begin
    total_d   = total_q;
    time_up_d = time_up_q;
    if (clear) begin
      total_d   = '0;
      time_up_d = 1'b0;
    end else if (count_en && (total_q != LIMIT)) begin
      total_d = total_q + 7'd1;
      if (limit_hit) time_up_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      total_q   <= '0;
      time_up_q <= 1'b0;
    end else begin
      total_q   <= total_d;
      time_up_q <= time_up_d;
    end
  end

  assign time_up = time_up_q;
`else
  // The limit only matters in the timeout build.
  localparam int TIME_LIMIT_UNUSED = TIME_LIMIT_S;
  assign limit_hit = 1'b0;
  assign time_up   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && !pause) state_d = ST_RUN;
        ST_RUN: begin
          if (game_over_in || sat_hit || limit_hit) state_d = ST_HALT;
          else if (pause)                           state_d = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (game_over_in)         state_d = ST_HALT;
          else if (start && !pause) state_d = ST_RUN;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      slow_prev_q <= 1'b0;
      tick_q      <= 1'b0;
      colon_q     <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slow_prev_q <= slow_clk;
      tick_q      <= count_en;
      colon_q     <= (state_d == ST_RUN) ? slow_clk : 1'b1;
      running_q   <= (state_d == ST_RUN);
    end
  end

  assign tick_1s  = tick_q;
  assign colon_on = colon_q;
  assign running  = running_q;

  bcd_digit_counter #(.MAX(DEC_MAX)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .en(count_en), .clr(clear), .q(sec_ones), .carry(c_so)
  );
  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .en(c_so), .clr(clear), .q(sec_tens), .carry(c_st)
  );
  bcd_digit_counter #(.MAX(DEC_MAX)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .en(c_st), .clr(clear), .q(min_ones), .carry(c_mo)
  );
  bcd_digit_counter #(.MAX(DEC_MAX)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .en(c_mo), .clr(clear), .q(min_tens), .carry(mt_carry_unused)
  );
endmodule

// File: tb/tb_game_clock_bcd.sv
// Bench for game_clock_bcd: elapsed-seconds reference model checked every cycle, plus directed
// literal checks of the key scenarios and a randomized control/slow_clk phase.
module tb_game_clock_bcd;
`ifdef GAME_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int LIM   = 10;
`else
  localparam bit TO_EN = 1'b0;
  localparam int LIM   = 120;
`endif
  localparam int MAXM = 99;
  localparam int MAXS = MAXM * 60 + 59;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slow_clk = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0, game_over_in = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic colon_on, running, tick_1s, time_up;

  always #5 clk = ~clk;

  game_clock_bcd #(.MAX_MIN(MAXM), .TIME_LIMIT_S(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start(start), .pause(pause),
    .clear(clear), .game_over_in(game_over_in),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .colon_on(colon_on), .running(running), .tick_1s(tick_1s), .time_up(time_up)
  );

  int total = 0, bad = 0, ticks_seen = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int bcd(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return ((mm / 10) << 12) | ((mm % 10) << 8) | ((ss / 10) << 4) | (ss % 10);
  endfunction

  function automatic int dut_time();
    return int'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  // Reference: play time as an integer number of seconds, plus a four-state game state.
  int m_secs = 0, m_st = S_IDLE;
  bit m_prev = 1'b0, m_tick = 1'b0, m_colon = 1'b1, m_tu = 1'b0;

  always @(posedge clk) begin : model
    bit e, sat, lim;
    int nst;
    if (!rst_n) begin
      m_secs = 0; m_st = S_IDLE; m_prev = 1'b0; m_tick = 1'b0; m_colon = 1'b1; m_tu = 1'b0;
    end else begin
      e = slow_clk && !m_prev;
      m_prev = slow_clk;
      sat = 1'b0; lim = 1'b0; nst = m_st;
      m_tick = 1'b0;
      if (clear) begin
        m_secs = 0; m_tu = 1'b0; nst = S_IDLE;
      end else begin
        if (m_st == S_RUN && e) begin
          if (m_secs == MAXS) sat = 1'b1;
          else begin
            m_secs++;
            m_tick = 1'b1;
            if (TO_EN && m_secs == LIM) begin lim = 1'b1; m_tu = 1'b1; end
          end
        end
        case (m_st)
          S_IDLE:  if (start && !pause) nst = S_RUN;
          S_RUN:   if (game_over_in || sat || lim) nst = S_HALT; else if (pause) nst = S_PAUSE;
          S_PAUSE: if (game_over_in) nst = S_HALT; else if (start && !pause) nst = S_RUN;
          default: ;
        endcase
      end
      m_colon = (nst == S_RUN) ? slow_clk : 1'b1;
      m_st = nst;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_digits", dut_time(), bcd(m_secs));
      chk("cyc_colon", int'(colon_on), int'(m_colon));
      chk("cyc_running", int'(running), int'(m_st == S_RUN));
      chk("cyc_tick", int'(tick_1s), int'(m_tick));
      chk("cyc_time_up", int'(time_up), int'(m_tu));
      if (tick_1s) ticks_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edges(input int n, input int h);
    repeat (n) begin
      slow_clk = 1'b1; cyc(h);
      slow_clk = 1'b0; cyc(h);
    end
  endtask

  task automatic pulse_start();  start = 1'b1; cyc(1); start = 1'b0; endtask
  task automatic pulse_pause();  pause = 1'b1; cyc(1); pause = 1'b0; endtask
  task automatic pulse_clear();  clear = 1'b1; cyc(1); clear = 1'b0; cyc(1); endtask

  initial begin
    int cnt;
    cyc(2);
    chk_on = 1'b1;
    chk("rst_digits", dut_time(), 0);
    chk("rst_colon", int'(colon_on), 1);
    chk("rst_running", int'(running), 0);
    chk("rst_tick", int'(tick_1s), 0);
    chk("rst_time_up", int'(time_up), 0);
    rst_n = 1'b1;
    cyc(2);

`ifndef GAME_TIMEOUT_EN
    pulse_start();
    ticks_seen = 0;
    edges(61, $urandom_range(1, 3));
    chk("t2_time_0101", dut_time(), 'h0101);
    chk("t2_tick_count", ticks_seen, 61);
    pulse_clear();
`endif

    pulse_start();
    edges(5, 2);
    chk("t3_time_0005", dut_time(), 'h0005);
    pulse_pause();
    chk("t3_paused", int'(running), 0);
    slow_clk = 1'b1; cyc(2); slow_clk = 1'b0; cyc(2);
    slow_clk = 1'b1; cyc(2); slow_clk = 1'b0; cyc(2);
    slow_clk = 1'b1; cyc(2);
    pulse_start();
    cyc(3);
    chk("t3_no_burst", dut_time(), 'h0005);
    chk("t3_resumed", int'(running), 1);
    slow_clk = 1'b0; cyc(2); slow_clk = 1'b1; cyc(2); slow_clk = 1'b0; cyc(2);
    chk("t3_time_0006", dut_time(), 'h0006);

    slow_clk = 1'b1; clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t5_clr_tick", int'(tick_1s), 0);
    chk("t5_clr_time", dut_time(), 0);
    chk("t5_clr_idle", int'(running), 0);
    slow_clk = 1'b0; cyc(2);

    pulse_start();
    edges(2, 2);
    game_over_in = 1'b1; pause = 1'b1;
    cyc(1);
    game_over_in = 1'b0; pause = 1'b0;
    cyc(1);
    chk("t5_go_halt", int'(running), 0);
    pulse_start();
    edges(1, 2);
    chk("t5_halt_stuck", int'(running), 0);
    chk("t5_halt_frozen", dut_time(), 'h0002);
    pulse_clear();

`ifndef GAME_TIMEOUT_EN
    pulse_start();
    edges(599, 1);
    chk("t4_time_0959", dut_time(), 'h0959);
    edges(1, 1);
    chk("t4_time_1000", dut_time(), 'h1000);
    edges(5399, 1);
    chk("t4_time_9959", dut_time(), 'h9959);
    chk("t4_running_9959", int'(running), 1);
    ticks_seen = 0;
    edges(1, 1);
    chk("t4_sat_hold", dut_time(), 'h9959);
    chk("t4_sat_halt", int'(running), 0);
    chk("t4_sat_no_tick", ticks_seen, 0);
    pulse_start();
    edges(1, 1);
    chk("t4_sat_stuck", int'(running), 0);
    pulse_clear();
`else
    pulse_start();
    edges(10, 2);
    chk("t6_time_0010", dut_time(), 'h0010);
    chk("t6_time_up", int'(time_up), 1);
    chk("t6_halt", int'(running), 0);
    pulse_clear();
    chk("t6_time_up_clr", int'(time_up), 0);
    chk("t6_digits_clr", dut_time(), 0);
`endif

    cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (cnt == 0) begin
        slow_clk = ~slow_clk;
        cnt = $urandom_range(1, 4);
      end
      cnt--;
      start        = ($urandom_range(0, 7) == 0);
      pause        = ($urandom_range(0, 39) == 0);
      clear        = ($urandom_range(0, 199) == 0);
      game_over_in = ($urandom_range(0, 299) == 0);
      rst_n        = ($urandom_range(0, 999) != 0);
      cyc(1);
    end
    rst_n = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; game_over_in = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
